accum_mask_pipe: RTL and testbench

ACCUM_MASK_PIPE -- requirements
Module: accum_mask_pipe

---
 rtl/accum_mask_pipe_if.sv | 16 +
 rtl/accum_mask_pipe.sv | 44 ++++
 tb/tb_accum_mask_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/accum_mask_pipe_if.sv
// accum_mask_pipe_if: control, operand and result signals of accum_mask_pipe
interface accum_mask_pipe_if #(parameter int WIDTH = 8);
    logic             en;
    logic             clr;
    logic             in_valid;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d_out;
    logic [WIDTH-1:0] f;
    logic             out_valid;
    logic             ovf;
    modport master (output en, clr, in_valid, mode, a, b, c, input d_out, f, out_valid, ovf);
    modport slave  (input en, clr, in_valid, mode, a, b, c, output d_out, f, out_valid, ovf);
endinterface

// File: rtl/accum_mask_pipe.sv
// accum_mask_pipe: wrapping/saturating accumulator with a mode-selected registered result
module accum_mask_pipe #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input logic clk,
    input logic rst,
    accum_mask_pipe_if.slave bus
);
    logic [WIDTH-1:0] d, f, d_nxt, f_nxt;
    logic [WIDTH:0]   sum;
    logic             vld, ovf, acc;
    assign acc   = bus.en & bus.in_valid & ~bus.clr;
    assign sum   = {1'b0, d} + {1'b0, bus.b | bus.c};
    assign d_nxt = (SAT && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    // f_nxt uses the pre-update d, so INC reports the old accumulator plus one
    assign f_nxt = bus.mode == 2'b00 ? f & bus.a & bus.b :
                   bus.mode == 2'b01 ? d + WIDTH'(1) :
                   bus.mode == 2'b10 ? (bus.a ^ bus.b) | (bus.c ^ bus.a) : f;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d   <= '0;
            f   <= '0;
            vld <= 1'b0;
            ovf <= 1'b0;
        end else if (bus.clr) begin
            d   <= '0;
            f   <= '0;
            vld <= 1'b0;
            ovf <= 1'b0;
        end else begin
            vld <= acc;
            if (acc) begin
                d   <= d_nxt;
                f   <= f_nxt;
                ovf <= ovf | sum[WIDTH];
            end
        end
    end
    assign bus.d_out     = d;
    assign bus.f         = f;
    assign bus.out_valid = vld;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_accum_mask_pipe.sv
// tb_accum_mask_pipe: directed table plus hand sequences, wrap (u0) and saturating (u1) instances
module tb_accum_mask_pipe;
    localparam logic [1:0] MASK = 2'b00, INC = 2'b01, XOR = 2'b10, HOLD = 2'b11;
    typedef struct {
        logic       en, clr, iv;
        logic [1:0] mode;
        logic [7:0] a, b, c, d, f;
        logic       ov, ovf;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    accum_mask_pipe_if #(.WIDTH(8)) b0 ();
    accum_mask_pipe_if #(.WIDTH(8)) b1 ();
    accum_mask_pipe #(.WIDTH(8), .SAT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    accum_mask_pipe #(.WIDTH(8), .SAT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    always #5 clk = ~clk;

    function automatic vec_t mk(logic en, logic clr, logic iv, logic [1:0] mode,
                                logic [7:0] a, logic [7:0] b, logic [7:0] c,
                                logic [7:0] d, logic [7:0] f, logic ov, logic ovf);
        vec_t v;
        v.en = en; v.clr = clr; v.iv = iv; v.mode = mode;
        v.a = a; v.b = b; v.c = c; v.d = d; v.f = f; v.ov = ov; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk0(string tag, logic [7:0] d, logic [7:0] f, logic ov, logic ovf);
        chk({tag, ".d"}, b0.d_out, d);
        chk({tag, ".f"}, b0.f, f);
        chk({tag, ".ov"}, {7'd0, b0.out_valid}, {7'd0, ov});
        chk({tag, ".ovf"}, {7'd0, b0.ovf}, {7'd0, ovf});
    endtask

    task automatic drive(logic en, logic clr, logic iv, logic [1:0] mode,
                         logic [7:0] a, logic [7:0] b, logic [7:0] c);
        b0.en = en; b0.clr = clr; b0.in_valid = iv; b0.mode = mode; b0.a = a; b0.b = b; b0.c = c;
        b1.en = en; b1.clr = clr; b1.in_valid = iv; b1.mode = mode; b1.a = a; b1.b = b; b1.c = c;
    endtask

    task automatic step(logic en, logic clr, logic iv, logic [1:0] mode,
                        logic [7:0] a, logic [7:0] b, logic [7:0] c);
        drive(en, clr, iv, mode, a, b, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, HOLD, 8'h00, 8'h00, 8'h00);
        #3;
        chk0("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        #9 rst = 1'b1;
        // mid-stream reset discards the in-flight result
        step(1, 0, 1, HOLD, 8'h00, 8'h5A, 8'h00);
        chk0("pre_rst", 8'h5A, 8'h00, 1'b1, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk0("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b1;
        step(1, 0, 1, HOLD, 8'h00, 8'h03, 8'h00);
        chk0("first_acc", 8'h03, 8'h00, 1'b1, 1'b0);
        step(1, 0, 0, HOLD, 8'h00, 8'h00, 8'h00);
        chk0("post_rst_idle", 8'h03, 8'h00, 1'b0, 1'b0);

        tbl.push_back(mk(0, 1, 0, HOLD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, HOLD, 8'h00, 8'h0F, 8'h30, 8'h3F, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 1, HOLD, 8'h00, 8'h0F, 8'h30, 8'h7E, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 1, HOLD, 8'h00, 8'h0F, 8'h30, 8'hBD, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 0, XOR,  8'hFF, 8'hFF, 8'hFF, 8'hBD, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, XOR,  8'hA5, 8'h3C, 8'h0F, 8'hFC, 8'hBB, 1, 0));
        tbl.push_back(mk(1, 0, 1, MASK, 8'hF0, 8'h3F, 8'h00, 8'h3B, 8'h30, 1, 1));
        tbl.push_back(mk(1, 1, 1, XOR,  8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, XOR,  8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 1, 0));
        tbl.push_back(mk(1, 0, 1, HOLD, 8'h00, 8'hFE, 8'h00, 8'hFF, 8'h01, 1, 0));
        tbl.push_back(mk(1, 0, 1, INC,  8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 1, INC,  8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1));
        tbl.push_back(mk(1, 0, 1, INC,  8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 1, XOR, 8'h12, 8'h34, 8'h56, 8'h00, 8'h01, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 0, 0, XOR, 8'h12, 8'h34, 8'h56, 8'h00, 8'h01, 0, 1));
        tbl.push_back(mk(0, 1, 0, HOLD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].iv, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].c);
            chk0($sformatf("vec%0d", i), tbl[i].d, tbl[i].f, tbl[i].ov, tbl[i].ovf);
        end

        // overflow: wrap versus saturate, ovf sticky afterwards
        step(1, 1, 0, HOLD, 8'h00, 8'h00, 8'h00);
        step(1, 0, 1, HOLD, 8'h00, 8'hF0, 8'h00);
        chk("sat0.d_f0", b0.d_out, 8'hF0);
        chk("sat1.d_f0", b1.d_out, 8'hF0);
        step(1, 0, 1, HOLD, 8'h00, 8'h20, 8'h00);
        chk0("sat0.ovf", 8'h10, 8'h00, 1'b1, 1'b1);
        chk("sat1.d", b1.d_out, 8'hFF);
        chk("sat1.ovf", {7'd0, b1.ovf}, 8'h01);
        step(1, 0, 1, INC, 8'h00, 8'h00, 8'h00);
        chk0("sat0.sticky", 8'h10, 8'h11, 1'b1, 1'b1);
        chk("sat1.d_hold", b1.d_out, 8'hFF);
        chk("sat1.inc_wrap", b1.f, 8'h00);
        chk("sat1.sticky", {7'd0, b1.ovf}, 8'h01);
        chk("sat1.ov", {7'd0, b1.out_valid}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
